// File: rtl/spi_avalon_bridge_if.sv
// Signal bundle between the SPI pins, the Avalon-MM slave side and the bridge status outputs.
// "master" is the bridge's view (it masters the Avalon bus); "slave" is the far side.
interface spi_avalon_bridge_if;
  logic        spi_sck;
  logic        spi_cs_n;
  logic        spi_mosi;
  logic        spi_miso;
  logic [15:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
  logic        busy;
  logic        err_timeout;

  modport master (
    input  spi_sck, spi_cs_n, spi_mosi, avm_readdata, avm_waitrequest,
    output spi_miso, avm_address, avm_read, avm_write, avm_writedata, busy, err_timeout
  );

  modport slave (
    output spi_sck, spi_cs_n, spi_mosi, avm_readdata, avm_waitrequest,
    input  spi_miso, avm_address, avm_read, avm_write, avm_writedata, busy, err_timeout
  );
endinterface

// File: rtl/spi_avalon_bridge.sv
// SPI mode-0 slave that decodes fixed 7/8-byte frames into single 32-bit Avalon-MM
// reads/writes. SPI pins are oversampled in the clock domain.
module spi_avalon_bridge #(
  parameter int          SYNC_STAGES    = 2,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_PATTERN    = 32'hDEADBEEF
) (
  input logic                 clock,
  input logic                 reset,
  spi_avalon_bridge_if.master bus
);

  localparam int         TO_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h02;

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_ADDR, S_WDATA, S_WR_REQ, S_RD_REQ, S_TX, S_DONE, S_DISCARD
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sck_prev;
  logic                   r_cs_prev;

  logic w_sck;
  logic w_cs;
  logic w_mosi;
  logic w_sck_rise;
  logic w_sck_fall;
  logic w_cs_fall;

  logic [2:0]  r_bit_cnt;
  logic [3:0]  r_byte_cnt;
  logic [6:0]  r_shift_in;
  logic [7:0]  r_addr_hi;
  logic [7:0]  r_addr_lo;
  logic [23:0] r_wdata_hi;
  logic        r_cmd_read;
  logic [7:0]  w_byte_val;
  logic        w_byte_done;

  logic            r_avm_read;
  logic            r_avm_write;
  logic [15:0]     r_avm_address;
  logic [31:0]     r_avm_writedata;
  logic [TO_W-1:0] r_to_cnt;
  logic            r_err_timeout;
  logic [31:0]     r_rd_data;
  logic            r_rd_valid;
  logic            r_req_live;

  logic [30:0] r_tx_shift;
  logic        r_miso;
  logic [31:0] w_tx_word;
  logic        r_busy;

  logic w_start_rd;
  logic w_start_wr;
  logic w_load_tx;

  // Pin synchronisers; cs_n idles high so reset must not create a false falling edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sck_sync  <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_sck_prev  <= 1'b0;
      r_cs_prev   <= 1'b1;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], bus.spi_sck};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], bus.spi_cs_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi};
      r_sck_prev  <= w_sck;
      r_cs_prev   <= w_cs;
    end
  end

  assign w_sck       = r_sck_sync[SYNC_STAGES-1];
  assign w_cs        = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
  assign w_sck_rise  = w_sck & ~r_sck_prev & ~w_cs;
  assign w_sck_fall  = ~w_sck & r_sck_prev & ~w_cs;
  assign w_cs_fall   = ~w_cs & r_cs_prev;
  assign w_byte_val  = {r_shift_in, w_mosi};
  assign w_byte_done = w_sck_rise && (r_bit_cnt == 3'd7);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_bit_cnt  <= '0;
      r_byte_cnt <= '0;
      r_shift_in <= '0;
      r_addr_hi  <= '0;
      r_addr_lo  <= '0;
      r_wdata_hi <= '0;
      r_cmd_read <= 1'b0;
    end else if (w_cs || w_cs_fall) begin
      r_bit_cnt  <= '0;
      r_byte_cnt <= '0;
    end else if (w_sck_rise) begin
      r_shift_in <= w_byte_val[6:0];
      r_bit_cnt  <= r_bit_cnt + 3'd1;
      if (r_bit_cnt == 3'd7) begin
        if (r_byte_cnt != 4'hF) begin
          r_byte_cnt <= r_byte_cnt + 4'd1;
        end
        case (r_byte_cnt)
          4'd0:             r_cmd_read <= (w_byte_val == CMD_READ);
          4'd1:             r_addr_hi  <= w_byte_val;
          4'd2:             r_addr_lo  <= w_byte_val;
          4'd3, 4'd4, 4'd5: r_wdata_hi <= {r_wdata_hi[15:0], w_byte_val};
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_start_rd   = 1'b0;
    w_start_wr   = 1'b0;
    w_load_tx    = 1'b0;
    if (w_cs) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_cs_fall) w_state_next = S_CMD;
        end
        S_CMD: begin
          if (w_byte_done) begin
            w_state_next = (w_byte_val == CMD_WRITE || w_byte_val == CMD_READ) ? S_ADDR : S_DISCARD;
          end
        end
        S_ADDR: begin
          if (w_byte_done && r_byte_cnt == 4'd2) begin
            if (r_cmd_read) begin
              w_state_next = S_RD_REQ;
              w_start_rd   = 1'b1;
            end else begin
              w_state_next = S_WDATA;
            end
          end
        end
        S_WDATA: begin
          if (w_byte_done && r_byte_cnt == 4'd6) begin
            w_state_next = S_WR_REQ;
            w_start_wr   = 1'b1;
          end
        end
        S_WR_REQ: begin
          if (!r_avm_write && !r_avm_read) w_state_next = S_DONE;
        end
        // The falling edge after the 32nd bit launches the first read-data bit.
        S_RD_REQ: begin
          if (w_sck_fall && r_byte_cnt == 4'd4) begin
            w_state_next = S_TX;
            w_load_tx    = 1'b1;
          end
        end
        S_TX: begin
          if (w_byte_done && r_byte_cnt == 4'd7) w_state_next = S_DONE;
        end
        S_DONE, S_DISCARD: ;
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  // Bus requests outlive a frame abort; r_req_live marks whether the result still matters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_avm_read      <= 1'b0;
      r_avm_write     <= 1'b0;
      r_avm_address   <= '0;
      r_avm_writedata <= '0;
      r_to_cnt        <= '0;
      r_err_timeout   <= 1'b0;
      r_rd_data       <= '0;
      r_rd_valid      <= 1'b0;
      r_req_live      <= 1'b0;
    end else begin
      r_err_timeout <= 1'b0;
      if (r_state == S_IDLE) begin
        r_rd_valid <= 1'b0;
        r_req_live <= 1'b0;
      end
      if (r_avm_read || r_avm_write) begin
        if (!bus.avm_waitrequest) begin
          r_avm_read  <= 1'b0;
          r_avm_write <= 1'b0;
          r_to_cnt    <= '0;
          r_req_live  <= 1'b0;
          if (r_avm_read && r_req_live && r_state != S_IDLE) begin
            r_rd_data  <= bus.avm_readdata;
            r_rd_valid <= 1'b1;
          end
        end else if (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
          r_avm_read    <= 1'b0;
          r_avm_write   <= 1'b0;
          r_to_cnt      <= '0;
          r_req_live    <= 1'b0;
          r_err_timeout <= 1'b1;
        end else begin
          r_to_cnt <= r_to_cnt + TO_W'(1);
        end
      end else if (w_start_rd) begin
        r_avm_read    <= 1'b1;
        r_avm_address <= {r_addr_hi, w_byte_val};
        r_req_live    <= 1'b1;
      end else if (w_start_wr) begin
        r_avm_write     <= 1'b1;
        r_avm_address   <= {r_addr_hi, r_addr_lo};
        r_avm_writedata <= {r_wdata_hi, w_byte_val};
      end
    end
  end

  assign w_tx_word = r_rd_valid ? r_rd_data : ERR_PATTERN;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_tx_shift <= '0;
      r_miso     <= 1'b0;
    end else if (w_load_tx) begin
      r_tx_shift <= w_tx_word[30:0];
      r_miso     <= w_tx_word[31];
    end else if (r_state == S_TX) begin
      if (w_sck_fall) begin
        r_tx_shift <= {r_tx_shift[29:0], 1'b0};
        r_miso     <= r_tx_shift[30];
      end
    end else begin
      r_miso <= 1'b0;
    end
  end

  // Idle/done clear busy, so it falls one clock after the FSM lands there.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_busy <= 1'b0;
    end else if (r_state == S_IDLE || r_state == S_DONE) begin
      r_busy <= 1'b0;
    end else if (w_sck_rise) begin
      r_busy <= 1'b1;
    end
  end

  assign bus.spi_miso      = r_miso;
  assign bus.avm_address   = r_avm_address;
  assign bus.avm_read      = r_avm_read;
  assign bus.avm_write     = r_avm_write;
  assign bus.avm_writedata = r_avm_writedata;
  assign bus.busy          = r_busy;
  assign bus.err_timeout   = r_err_timeout;

endmodule

// File: tb/tb_spi_avalon_bridge.sv
// Directed and randomized SPI frames against a frame-level model of the bridge and a
// stalling Avalon slave; every comparison is an immediate assertion.
module tb_spi_avalon_bridge;

  localparam int          HALF = 8;
  localparam int          TO   = 40;
  localparam logic [31:0] ERR  = 32'hDEADBEEF;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  spi_avalon_bridge_if bus ();

  spi_avalon_bridge #(
    .SYNC_STAGES   (2),
    .TIMEOUT_CYCLES(TO),
    .ERR_PATTERN   (ERR)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  // Avalon slave: stalls each request stall_n cycles, then accepts.
  int          stall_n   = 0;
  int          stall_cnt = 0;
  logic [31:0] rd_value  = '0;
  int          wr_count  = 0;
  int          rd_count  = 0;
  int          rd_high   = 0;
  int          err_cycles = 0;
  int          both_high = 0;
  logic [15:0] last_addr  = '0;
  logic [31:0] last_wdata = '0;

  assign bus.avm_waitrequest = (bus.avm_read || bus.avm_write) && (stall_cnt < stall_n);
  assign bus.avm_readdata    = rd_value;

  always @(posedge clock) begin
    if (bus.avm_read || bus.avm_write) begin
      if (bus.avm_waitrequest) begin
        stall_cnt <= stall_cnt + 1;
      end else begin
        stall_cnt <= 0;
        last_addr <= bus.avm_address;
        if (bus.avm_write) begin
          wr_count   <= wr_count + 1;
          last_wdata <= bus.avm_writedata;
        end else begin
          rd_count <= rd_count + 1;
        end
      end
    end else begin
      stall_cnt <= 0;
    end
    if (bus.avm_read) rd_high <= rd_high + 1;
    if (bus.avm_read && bus.avm_write) both_high <= both_high + 1;
    if (bus.err_timeout) err_cycles <= err_cycles + 1;
  end

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  logic [7:0] tx_buf[10];
  logic [7:0] rx_buf[10];
  logic       busy_end;
  logic       busy_after;

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      bus.spi_mosi = tx[i];
      tick(HALF);
      rx[i] = bus.spi_miso;
      bus.spi_sck = 1'b1;
      tick(HALF);
      bus.spi_sck = 1'b0;
    end
  endtask

  task automatic spi_frame(input int n);
    logic [7:0] r;
    bus.spi_cs_n = 1'b0;
    tick(HALF);
    for (int i = 0; i < n; i++) begin
      spi_byte(tx_buf[i], r);
      rx_buf[i] = r;
    end
    tick(2 * HALF);
    busy_end = bus.busy;
    bus.spi_cs_n = 1'b1;
    tick(4 * HALF);
    busy_after = bus.busy;
  endtask

  // Frame-level model: what the master should see on MISO and on the bus for one frame.
  task automatic run_frame(input string name, input int n, input int stall, input logic [31:0] rdv);
    int          wr0, rd0, hi0, er0;
    logic [7:0]  cmd;
    bit          is_wr, is_rd, full, ok_rd;
    logic [63:0] got, exp_rx;
    logic [31:0] exp_word;
    int          exp_high;
    wr0 = wr_count; rd0 = rd_count; hi0 = rd_high; er0 = err_cycles;
    stall_n  = stall;
    rd_value = rdv;
    spi_frame(n);

    cmd   = tx_buf[0];
    is_wr = (cmd == 8'h01) && (n >= 7);
    is_rd = (cmd == 8'h02) && (n >= 3);
    full  = ((cmd == 8'h01) && (n >= 7)) || ((cmd == 8'h02) && (n >= 8));
    ok_rd = is_rd && (stall < TO);
    exp_word = ok_rd ? rdv : ERR;
    exp_rx   = ((cmd == 8'h02) && (n >= 8)) ? {32'h0, exp_word} : 64'h0;
    exp_high = is_rd ? ((stall < TO) ? stall + 1 : TO) : 0;

    got = '0;
    for (int i = 0; i < 8; i++) got = {got[55:0], (i < n) ? rx_buf[i] : 8'h00};
    $display("frame %s: n=%0d cmd=%02h stall=%0d miso=%016h", name, n, cmd, stall, got);

    check({name, "_miso"}, got, exp_rx);
    if (n > 8) check({name, "_extra_miso"}, 64'(rx_buf[8]), 64'h0);
    check({name, "_writes"}, 64'(wr_count - wr0), is_wr ? 64'd1 : 64'd0);
    check({name, "_reads"}, 64'(rd_count - rd0), ok_rd ? 64'd1 : 64'd0);
    check({name, "_read_cycles"}, 64'(rd_high - hi0), 64'(exp_high));
    check({name, "_timeout_pulse"}, 64'(err_cycles - er0),
          ((is_wr || is_rd) && stall >= TO) ? 64'd1 : 64'd0);
    check({name, "_busy_end"}, 64'(busy_end), full ? 64'd0 : 64'd1);
    check({name, "_busy_after"}, 64'(busy_after), 64'd0);
    if (is_wr) begin
      check({name, "_waddr"}, 64'(last_addr), 64'({tx_buf[1], tx_buf[2]}));
      check({name, "_wdata"}, 64'(last_wdata), 64'({tx_buf[3], tx_buf[4], tx_buf[5], tx_buf[6]}));
    end else if (ok_rd) begin
      check({name, "_raddr"}, 64'(last_addr), 64'({tx_buf[1], tx_buf[2]}));
    end
  endtask

  initial begin
    logic [7:0]  cmd, r;
    logic [31:0] d;
    int          n, kind;

    bus.spi_sck  = 1'b0;
    bus.spi_cs_n = 1'b1;
    bus.spi_mosi = 1'b0;
    tick(4);
    check("reset_ctrl", 64'({bus.spi_miso, bus.avm_read, bus.avm_write, bus.busy, bus.err_timeout}), 64'h0);
    check("reset_addr_data", {16'h0, bus.avm_address, bus.avm_writedata}, 64'h0);
    reset = 1'b0;
    tick(4);

    // Plain write, no stall.
    tx_buf[0] = 8'h01; tx_buf[1] = 8'h01; tx_buf[2] = 8'h00;
    tx_buf[3] = 8'h00; tx_buf[4] = 8'h00; tx_buf[5] = 8'h00; tx_buf[6] = 8'h2A;
    run_frame("t1_write", 7, 0, 32'h0);

    // Read with one stall cycle.
    tx_buf[0] = 8'h02; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00;
    for (int i = 3; i < 8; i++) tx_buf[i] = 8'h00;
    run_frame("t2_read", 8, 1, 32'h0000_0014);

    // Stuck slave: timeout and error pattern.
    tx_buf[1] = 8'h03; tx_buf[2] = 8'h04;
    run_frame("t3_timeout", 8, 1000, 32'h1234_5678);

    // Write aborted after 4 bytes, then a full write.
    tx_buf[0] = 8'h01; tx_buf[1] = 8'hAB; tx_buf[2] = 8'hCD; tx_buf[3] = 8'h99;
    run_frame("t4_abort", 4, 0, 32'h0);
    tx_buf[4] = 8'h55; tx_buf[5] = 8'h66; tx_buf[6] = 8'h77;
    run_frame("t4_after", 7, 2, 32'h0);

    // Invalid command.
    tx_buf[0] = 8'h7F;
    for (int i = 1; i < 8; i++) tx_buf[i] = 8'hFF;
    run_frame("t5_badcmd", 8, 0, 32'h0);

    for (int k = 0; k < 10; k++) begin
      kind = $urandom_range(0, 2);
      cmd  = (kind == 0) ? 8'h01 : (kind == 1) ? 8'h02 : 8'($urandom_range(3, 255));
      for (int i = 0; i < 10; i++) tx_buf[i] = 8'($urandom);
      tx_buf[0] = cmd;
      n = (kind == 0) ? 7 : (kind == 1) ? 8 : $urandom_range(1, 8);
      if (kind != 2) n = n + $urandom_range(0, 1);
      d = $urandom;
      run_frame($sformatf("rand%0d", k), n, $urandom_range(0, 4), d);
    end

    // Reset while a read request is stalled on the bus.
    stall_n = 1000;
    tx_buf[0] = 8'h02; tx_buf[1] = 8'h12; tx_buf[2] = 8'h34;
    bus.spi_cs_n = 1'b0;
    tick(HALF);
    for (int i = 0; i < 3; i++) spi_byte(tx_buf[i], r);
    tick(4);
    check("t6_read_pending", 64'({bus.avm_read, bus.busy}), 64'h3);
    #2;
    reset = 1'b1;
    #1;
    $display("frame t6_reset: read=%0b addr=%04h busy=%0b", bus.avm_read, bus.avm_address, bus.busy);
    check("t6_reset_ctrl", 64'({bus.spi_miso, bus.avm_read, bus.avm_write, bus.busy, bus.err_timeout}), 64'h0);
    check("t6_reset_addr_data", {16'h0, bus.avm_address, bus.avm_writedata}, 64'h0);
    bus.spi_cs_n = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(4 * HALF);
    check("never_read_and_write", 64'(both_high), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
